// File: rtl/crc_appender_if.sv
// Serial bit-stream bundle around the CRC framing stage: upstream bit/flags,
// downstream bit/last and the debug CRC view.
interface crc_appender_if;
  localparam int unsigned CRC_W = 16;

  logic             in_valid;
  logic             in_bit;
  logic             in_sof;
  logic             in_eof;
  logic             in_ready;
  logic             output_data;
  logic             out_valid;
  logic             out_last;
  logic [CRC_W-1:0] crc_value;

  // Environment side: presents upstream bits, observes the framed stream.
  modport master (
    output in_valid, in_bit, in_sof, in_eof,
    input  in_ready, output_data, out_valid, out_last, crc_value
  );

  // Framing stage side.
  modport slave (
    input  in_valid, in_bit, in_sof, in_eof,
    output in_ready, output_data, out_valid, out_last, crc_value
  );
endinterface

// File: rtl/crc_appender.sv
// Serial CRC-16 framing stage: passes bits through with one cycle of latency,
// folds covered bits into the CRC and appends the CRC MSB-first after the frame.
module crc_appender #(
  parameter logic [15:0] POLY    = 16'h1021,
  parameter logic [15:0] INIT    = 16'hFFFF,
  parameter logic [15:0] XOR_OUT = 16'h0000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           trigger,
  crc_appender_if.slave  bus
);

  localparam int unsigned CRC_W = 16;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    APPEND  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CRC_W-1:0] crc, crc_d;
  logic [CRC_W-1:0] shreg, shreg_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             ready_c;
  logic             accept;
  logic [CRC_W-1:0] crc_next;

  // One serial step of the MSB-first CRC shift register.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    return {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ b) ? POLY : CRC_W'(0));
  endfunction

  assign ready_c      = trigger & (state != APPEND);
  assign accept       = bus.in_valid & ready_c;
  assign bus.in_ready = ready_c;

  // Next-state and next-output logic; trigger low leaves everything in place.
  always_comb begin
    state_d  = state;
    crc_d    = crc;
    shreg_d  = shreg;
    cnt_d    = cnt;
    data_d   = data_q;
    valid_d  = 1'b0;
    last_d   = 1'b0;
    crc_next = crc_step(((state == IDLE) || bus.in_sof) ? INIT : crc, bus.in_bit);

    case (state)
      IDLE, PAYLOAD: begin
        if (accept) begin
          data_d  = bus.in_bit;
          valid_d = 1'b1;
          // Uncovered bits in IDLE (preamble, stray eof) only pass through.
          if (bus.in_sof || (state == PAYLOAD)) begin
            crc_d = crc_next;
            if (bus.in_eof) begin
              shreg_d = crc_next ^ XOR_OUT;
              cnt_d   = CNT_W'(CRC_W - 1);
              state_d = APPEND;
            end else begin
              state_d = PAYLOAD;
            end
          end
        end
      end

      APPEND: begin
        if (trigger) begin
          data_d  = shreg[CRC_W-1];
          valid_d = 1'b1;
          shreg_d = {shreg[CRC_W-2:0], 1'b0};
          cnt_d   = CNT_W'(cnt - CNT_W'(1));
          if (cnt == '0) begin
            last_d  = 1'b1;
            cnt_d   = '0;
            crc_d   = INIT;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      crc     <= INIT;
      shreg   <= '0;
      cnt     <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_d;
      crc     <= crc_d;
      shreg   <= shreg_d;
      cnt     <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus.output_data = data_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_last    = last_q;
  assign bus.crc_value   = crc;

endmodule
